tuner_sequencer: RTL and testbench
==================================

Name: tuner_sequencer

Overview:
Upstream command sequencer for the per-ring tuner FSM. It walks NUM_CH channels in order. For each channel it issues INIT, SEARCH and LOCK (tuner_cmd_e) over a valid/ready link, then watches the tuner's tuner_state_e until that step completes. It handles ERROR and timeouts with bounded retries, tracks which channels are locked, and issues UNLOCK on request.

Parameters:
NUM_CH, 4, number of tuner channels (rings); ≥1
TIMEOUT_CYCLES, 1024, maximum cycles to wait for DONE/ERROR after a command handshake
MAX_RETRY, 3, retries per channel before a hard fail; 0 means fail on the first error
CH_W, $clog2(NUM_CH) (minimum 1), channel index width (localparam)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start_i  in  1  pulse; begins a full tuning pass from channel 0
abort_i  in  1  pulse; stops any operation and returns to IDLE
unlock_req_i  in  1  pulse; UNLOCKs every locked channel
cmd_valid_o  out  1  command valid
cmd_ready_i  in  1  tuner accepts the command
cmd_o  out  `TUNER_CMD_WIDTH  tuner_cmd_e command
ch_sel_o  out  CH_W  channel addressed by cmd_o and by the watched state
tuner_state_i  in  `TUNER_STATE_WIDTH  tuner_state_e of the selected channel
busy_o  out  1  sequencer not in IDLE/FAIL
done_o  out  1  one-cycle pulse when a tuning or unlock pass completes successfully
error_o  out  1  sticky hard-fail flag
err_ch_o  out  CH_W  channel that caused the hard fail
locked_mask_o  out  NUM_CH  bit i set means channel i is locked

Behaviour:
- Reset values: every output is 0. cmd_o = INIT. FSM = S_IDLE. Retry and timeout counters = 0.
- FSM states: S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_UNLK_ISSUE, S_UNLK_WAIT, S_FAIL.
- S_IDLE:
  - start_i: clear locked_mask_o and error_o, ch = 0, step = INIT, go to S_ISSUE.
  - unlock_req_i with locked_mask_o ≠ 0: ch = lowest set bit, go to S_UNLK_ISSUE.
  - unlock_req_i with mask = 0: done_o pulses the next cycle.
- S_ISSUE:
  - cmd_valid_o = 1. cmd_o and ch_sel_o are held stable until cmd_valid_o & cmd_ready_i.
  - On the handshake: clear the timeout counter, go to S_WAIT.
- S_WAIT:
  - tuner_state_i is sampled starting the cycle after the handshake. By interface contract, the tuner does not present a stale DONE/ERROR in that cycle.
  - DONE, step INIT: step = SEARCH, go to S_ISSUE.
  - DONE, step SEARCH: step = LOCK, go to S_ISSUE.
  - DONE, step LOCK: set locked_mask_o[ch], go to S_NEXT.
  - ERROR, or the counter reaching TIMEOUT_CYCLES-1: if retry < MAX_RETRY, retry++, step = INIT, go to S_ISSUE. Otherwise go to S_FAIL with error_o = 1 and err_ch_o = ch.
  - Neither: counter++.
- S_NEXT: reset retry to 0.
  - ch == NUM_CH-1: done_o pulse, go to S_IDLE.
  - Otherwise: ch++, step = INIT, go to S_ISSUE.
  - Minimum pass latency is one cycle per channel in S_NEXT plus the three command/wait round trips.
- S_UNLK_ISSUE / S_UNLK_WAIT:
  - Same handshake with cmd_o = UNLOCK.
  - On DONE, clear locked_mask_o[ch], then move to the next set bit, or to done_o and S_IDLE when none remain.
  - ERROR or timeout goes directly to S_FAIL; there are no retries for UNLOCK.
- S_FAIL:
  - error_o is held, busy_o = 0.
  - start_i restarts a tuning pass; abort_i returns to S_IDLE; error_o clears only on start_i or rst.
- abort_i in any state: go to S_IDLE next cycle and drop cmd_valid_o. This is the only permitted valid withdrawal. locked_mask_o is kept.
- Simultaneous events:
  - abort_i beats start_i.
  - start_i beats unlock_req_i.
  - start_i or unlock_req_i while busy is ignored.
- rst mid-operation: every register returns to its reset value on the next edge, regardless of handshake state.

Decomposition:
- Add to tuner_pkg:
  - tuner_seq_state_e enum of the seven S_* states.
  - tuner_step_next() function mapping INIT→SEARCH→LOCK.
  - tuner_seq_state_to_string() for debug prints.
- Sub-module tuner_wait_timer: loadable timeout counter with clear, enable and expired outputs, parameterised by TIMEOUT_CYCLES.

Test Plan:
- NUM_CH=4, tuner always ready, DONE 5 cycles after each command → 12 handshakes in order INIT/SEARCH/LOCK for ch 0..3; locked_mask_o=4'b1111; single done_o pulse; error_o=0.
- Ch 2 SEARCH returns ERROR twice, then succeeds; MAX_RETRY=3 → ch 2 restarts at INIT twice; final mask=4'b1111; no error_o.
- Ch 1 never reaches DONE; TIMEOUT_CYCLES=16, MAX_RETRY=1 → two timeouts of 16 cycles each; error_o=1, err_ch_o=1, mask=4'b0001, busy_o=0.
- cmd_ready_i held low 7 cycles on ch 0 INIT → cmd_valid_o, cmd_o and ch_sel_o stable throughout; the handshake occurs on cycle 8.
- After a full lock pass, pulse unlock_req_i → UNLOCK issued to ch 0..3; mask goes 1111→0000; one done_o pulse.
- abort_i asserted in the same cycle as start_i, then again mid-S_WAIT on ch 2 → the first start is ignored; the mid-pass abort gives cmd_valid_o=0 and busy_o=0 the next cycle with mask=4'b0011 retained.

Source files
------------

// File: rtl/tuner_pkg.sv
// Shared tuner command/state encodings and sequencer FSM states.
// Widths are exported as macros so ports can be declared before the package is imported.
`ifndef TUNER_CMD_WIDTH
`define TUNER_CMD_WIDTH 2
`endif
`ifndef TUNER_STATE_WIDTH
`define TUNER_STATE_WIDTH 2
`endif

package tuner_pkg;

    typedef enum logic [`TUNER_CMD_WIDTH-1:0] {
        CMD_INIT   = 0,
        CMD_SEARCH = 1,
        CMD_LOCK   = 2,
        CMD_UNLOCK = 3
    } tuner_cmd_e;

    typedef enum logic [`TUNER_STATE_WIDTH-1:0] {
        TS_IDLE  = 0,
        TS_BUSY  = 1,
        TS_DONE  = 2,
        TS_ERROR = 3
    } tuner_state_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_UNLK_ISSUE,
        S_UNLK_WAIT,
        S_FAIL
    } tuner_seq_state_e;

    function automatic tuner_cmd_e tuner_step_next(input tuner_cmd_e step);
        case (step)
            CMD_INIT:   return CMD_SEARCH;
            CMD_SEARCH: return CMD_LOCK;
            default:    return CMD_LOCK;
        endcase
    endfunction

    function automatic string tuner_seq_state_to_string(input tuner_seq_state_e s);
        case (s)
            S_IDLE:       return "S_IDLE";
            S_ISSUE:      return "S_ISSUE";
            S_WAIT:       return "S_WAIT";
            S_NEXT:       return "S_NEXT";
            S_UNLK_ISSUE: return "S_UNLK_ISSUE";
            S_UNLK_WAIT:  return "S_UNLK_WAIT";
            S_FAIL:       return "S_FAIL";
            default:      return "S_UNKNOWN";
        endcase
    endfunction

endpackage

// File: rtl/tuner_sequencer_if.sv
// Command link between the sequencer (master) and the tuner FSM (slave).
// Valid/ready command channel plus the tuner state of the selected channel.
interface tuner_sequencer_if #(
    parameter int CH_W = 2
);
    import tuner_pkg::*;

    logic             cmd_valid_o;
    logic             cmd_ready_i;
    tuner_cmd_e       cmd_o;
    logic [CH_W-1:0]  ch_sel_o;
    tuner_state_e     tuner_state_i;

    modport master (
        output cmd_valid_o, cmd_o, ch_sel_o,
        input  cmd_ready_i, tuner_state_i
    );

    modport slave (
        input  cmd_valid_o, cmd_o, ch_sel_o,
        output cmd_ready_i, tuner_state_i
    );
endinterface

// File: rtl/tuner_sequencer_wait_timer.sv
// Wait-window counter: cleared on each command handshake, counts while enabled,
// expires on its TIMEOUT_CYCLES-th enabled cycle and saturates there.
module tuner_wait_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expired = (r_cnt == LAST);
endmodule

// File: rtl/tuner_sequencer.sv
// Walks every channel through INIT/SEARCH/LOCK with bounded retries, tracks locked
// channels and unlocks them on request; command held stable until accepted.
module tuner_sequencer
    import tuner_pkg::*;
#(
    parameter int  NUM_CH         = 4,
    parameter int  TIMEOUT_CYCLES = 1024,
    parameter int  MAX_RETRY      = 3,
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              unlock_req_i,
    tuner_sequencer_if.master tun_if,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [CH_W-1:0]   err_ch_o,
    output logic [NUM_CH-1:0] locked_mask_o
);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RETRY_W-1:0] MAX_RETRY_L = RETRY_W'(MAX_RETRY);
    localparam logic [CH_W-1:0]    CH_LAST     = CH_W'(NUM_CH - 1);

    tuner_seq_state_e    r_state;
    tuner_cmd_e          r_step;
    tuner_cmd_e          r_cmd;
    logic [CH_W-1:0]     r_ch;
    logic [RETRY_W-1:0]  r_retry;
    logic [NUM_CH-1:0]   r_mask;
    logic                r_cmd_valid;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic [CH_W-1:0]     r_err_ch;

    logic                w_hs;
    logic                w_expired;
    logic                w_wait;
    logic                w_tn_done;
    logic                w_tn_fail;
    logic [NUM_CH-1:0]   w_mask_rest;

    function automatic logic [CH_W-1:0] f_lowest(input logic [NUM_CH-1:0] m);
        f_lowest = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) f_lowest = CH_W'(i);
        end
    endfunction

    assign w_hs        = r_cmd_valid && tun_if.cmd_ready_i;
    assign w_wait      = (r_state == S_WAIT) || (r_state == S_UNLK_WAIT);
    assign w_tn_done   = (tun_if.tuner_state_i == TS_DONE);
    assign w_tn_fail   = (tun_if.tuner_state_i == TS_ERROR) || w_expired;
    assign w_mask_rest = r_mask & ~(NUM_CH'(1) << r_ch);

    tuner_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_hs),
        .i_en      (w_wait),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_step      <= CMD_INIT;
            r_cmd       <= CMD_INIT;
            r_ch        <= '0;
            r_retry     <= '0;
            r_mask      <= '0;
            r_cmd_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_ch    <= '0;
        end else begin
            r_done <= 1'b0;
            // Abort is the only case where a raised valid may be withdrawn.
            if (abort_i) begin
                r_state     <= S_IDLE;
                r_cmd_valid <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_FAIL: begin
                        if (start_i) begin
                            r_mask      <= '0;
                            r_error     <= 1'b0;
                            r_ch        <= '0;
                            r_retry     <= '0;
                            r_step      <= CMD_INIT;
                            r_cmd       <= CMD_INIT;
                            r_cmd_valid <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= S_ISSUE;
                        end else if ((r_state == S_IDLE) && unlock_req_i) begin
                            if (|r_mask) begin
                                r_ch        <= f_lowest(r_mask);
                                r_cmd       <= CMD_UNLOCK;
                                r_cmd_valid <= 1'b1;
                                r_busy      <= 1'b1;
                                r_state     <= S_UNLK_ISSUE;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    S_ISSUE: begin
                        if (w_hs) begin
                            r_cmd_valid <= 1'b0;
                            r_state     <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (w_tn_done) begin
                            if (r_step == CMD_LOCK) begin
                                r_mask[r_ch] <= 1'b1;
                                r_state      <= S_NEXT;
                            end else begin
                                r_step      <= tuner_step_next(r_step);
                                r_cmd       <= tuner_step_next(r_step);
                                r_cmd_valid <= 1'b1;
                                r_state     <= S_ISSUE;
                            end
                        end else if (w_tn_fail) begin
                            if (r_retry < MAX_RETRY_L) begin
                                r_retry     <= r_retry + RETRY_W'(1);
                                r_step      <= CMD_INIT;
                                r_cmd       <= CMD_INIT;
                                r_cmd_valid <= 1'b1;
                                r_state     <= S_ISSUE;
                            end else begin
                                r_error  <= 1'b1;
                                r_err_ch <= r_ch;
                                r_busy   <= 1'b0;
                                r_state  <= S_FAIL;
                            end
                        end
                    end
                    S_NEXT: begin
                        r_retry <= '0;
                        if (r_ch == CH_LAST) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_ch        <= r_ch + CH_W'(1);
                            r_step      <= CMD_INIT;
                            r_cmd       <= CMD_INIT;
                            r_cmd_valid <= 1'b1;
                            r_state     <= S_ISSUE;
                        end
                    end
                    S_UNLK_ISSUE: begin
                        if (w_hs) begin
                            r_cmd_valid <= 1'b0;
                            r_state     <= S_UNLK_WAIT;
                        end
                    end
                    S_UNLK_WAIT: begin
                        // Unlock has no retry path: any failure is terminal.
                        if (w_tn_done) begin
                            r_mask[r_ch] <= 1'b0;
                            if (|w_mask_rest) begin
                                r_ch        <= f_lowest(w_mask_rest);
                                r_cmd_valid <= 1'b1;
                                r_state     <= S_UNLK_ISSUE;
                            end else begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end
                        end else if (w_tn_fail) begin
                            r_error  <= 1'b1;
                            r_err_ch <= r_ch;
                            r_busy   <= 1'b0;
                            r_state  <= S_FAIL;
                        end
                    end
                    default: begin
                        r_cmd_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign tun_if.cmd_valid_o = r_cmd_valid;
    assign tun_if.cmd_o       = r_cmd;
    assign tun_if.ch_sel_o    = r_ch;
    assign busy_o             = r_busy;
    assign done_o             = r_done;
    assign error_o            = r_error;
    assign err_ch_o           = r_err_ch;
    assign locked_mask_o      = r_mask;
endmodule

// File: tb/tb_tuner_sequencer.sv
// Scoreboard bench: a pass-level reference model predicts the handshake stream and
// final lock/error outcome; a tuner model replies with DONE/ERROR/silence per policy.
module tb_tuner_sequencer;
    import tuner_pkg::*;

    localparam int NUM_CH = 4;
    localparam int TMO    = 16;
    localparam int MAXR   = 2;
    localparam int CH_W   = 2;

    typedef struct packed {
        tuner_cmd_e      cmd;
        logic [CH_W-1:0] ch;
    } hs_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i, abort_i, unlock_req_i;
    logic              busy_o, done_o, error_o;
    logic [CH_W-1:0]   err_ch_o;
    logic [NUM_CH-1:0] locked_mask_o;

    tuner_sequencer_if #(.CH_W(CH_W)) tif();

    tuner_sequencer #(
        .NUM_CH(NUM_CH), .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MAXR)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .unlock_req_i(unlock_req_i), .tun_if(tif), .busy_o(busy_o),
        .done_o(done_o), .error_o(error_o), .err_ch_o(err_ch_o),
        .locked_mask_o(locked_mask_o)
    );

    int n_chk = 0, n_err = 0, cyc = 0, hs_seen = 0, done_cnt = 0;
    hs_t exp_q[$];
    int  hs_cyc_q[$];
    int  pol_err[NUM_CH][3], m_err[NUM_CH][3];
    bit  pol_hang[NUM_CH][3], m_hang[NUM_CH][3];
    int  rdy_mode = 0, fixed_dly = 5;
    bit  rand_dly = 0;
    logic [NUM_CH-1:0] model_mask = '0;
    bit  exp_fail = 0, exp_done = 0, m_error = 0, m_in_fail = 0;
    int  exp_err_ch = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Ready driver
    initial begin
        tif.cmd_ready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       tif.cmd_ready_i = 1'b1;
                1:       tif.cmd_ready_i = ($urandom_range(0, 3) != 0);
                default: tif.cmd_ready_i = 1'b0;
            endcase
        end
    end

    task automatic respond(input tuner_cmd_e c, input int ch);
        int d, s;
        bit hang;
        tuner_state_e r;
        d = rand_dly ? int'($urandom_range(1, 8)) : fixed_dly;
        hang = 1'b0;
        r = TS_DONE;
        if (c != CMD_UNLOCK) begin
            s = int'(c);
            if (pol_hang[ch][s]) hang = 1'b1;
            else if (pol_err[ch][s] > 0) begin
                pol_err[ch][s]--;
                r = TS_ERROR;
            end
        end
        @(posedge clk); #1 tif.tuner_state_i = TS_BUSY;
        if (!hang) begin
            repeat (d) @(posedge clk);
            #1 tif.tuner_state_i = r;
            @(posedge clk); #1 tif.tuner_state_i = TS_IDLE;
        end
    endtask

    // Tuner model
    initial begin
        tif.tuner_state_i = TS_IDLE;
        forever begin
            @(negedge clk);
            if (!rst && tif.cmd_valid_o && tif.cmd_ready_i)
                respond(tif.cmd_o, int'(tif.ch_sel_o));
        end
    end

    // Monitor: pops expected handshakes, checks stability while stalled, counts done pulses
    initial begin
        bit   stall_vld;
        hs_t  stall, got, e;
        stall_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_vld = 1'b0;
            end else begin
                got = '{cmd: tif.cmd_o, ch: tif.ch_sel_o};
                if (tif.cmd_valid_o) begin
                    if (stall_vld) begin
                        chk("stall_cmd_stable", int'(got.cmd), int'(stall.cmd));
                        chk("stall_ch_stable", int'(got.ch), int'(stall.ch));
                    end
                    if (tif.cmd_ready_i) begin
                        hs_seen++;
                        hs_cyc_q.push_back(cyc);
                        stall_vld = 1'b0;
                        if (exp_q.size() == 0) begin
                            n_chk++; n_err++;
                            $display("FAIL unexpected_hs: got cmd=%0d ch=%0d, required none", got.cmd, got.ch);
                        end else begin
                            e = exp_q.pop_front();
                            chk("hs_cmd", int'(got.cmd), int'(e.cmd));
                            chk("hs_ch", int'(got.ch), int'(e.ch));
                        end
                    end else begin
                        stall_vld = 1'b1;
                        stall = got;
                    end
                end else begin
                    stall_vld = 1'b0;
                end
                if (done_o) done_cnt++;
            end
        end
    end

    task automatic set_pol(input int c, input int s, input int n, input bit h);
        pol_err[c][s] = n; m_err[c][s] = n;
        pol_hang[c][s] = h; m_hang[c][s] = h;
    endtask

    task automatic set_clean();
        for (int c = 0; c < NUM_CH; c++)
            for (int s = 0; s < 3; s++) set_pol(c, s, 0, 1'b0);
    endtask

    // Reference model of a tuning pass: channels in order, each step retried from INIT.
    task automatic build_expect();
        int retry, s;
        model_mask = '0;
        exp_fail = 1'b0;
        exp_err_ch = 0;
        for (int ch = 0; ch < NUM_CH && !exp_fail; ch++) begin
            retry = 0;
            s = 0;
            while (s < 3) begin
                exp_q.push_back('{cmd: tuner_cmd_e'(s), ch: CH_W'(ch)});
                if (m_hang[ch][s] || m_err[ch][s] > 0) begin
                    if (!m_hang[ch][s]) m_err[ch][s]--;
                    if (retry < MAXR) begin
                        retry++;
                        s = 0;
                    end else begin
                        exp_fail = 1'b1;
                        exp_err_ch = ch;
                        break;
                    end
                end else begin
                    s++;
                end
            end
            if (!exp_fail) model_mask[ch] = 1'b1;
        end
        exp_done = !exp_fail;
        m_error = exp_fail;
        m_in_fail = exp_fail;
    endtask

    task automatic build_unlock();
        for (int i = 0; i < NUM_CH; i++)
            if (model_mask[i]) exp_q.push_back('{cmd: CMD_UNLOCK, ch: CH_W'(i)});
        model_mask = '0;
        exp_fail = 1'b0;
        exp_done = 1'b1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
    endtask

    task automatic pulse_unlock();
        @(posedge clk); #1 unlock_req_i = 1'b1;
        @(posedge clk); #1 unlock_req_i = 1'b0;
    endtask

    task automatic pulse_abort();
        @(posedge clk); #1 abort_i = 1'b1;
        @(posedge clk); #1 abort_i = 1'b0;
    endtask

    task automatic finish_pass(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy_o && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy_o) begin
            n_chk++; n_err++;
            $display("FAIL %s_timeout: still busy in %s, required idle", tag,
                     tuner_seq_state_to_string(dut.r_state));
        end
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        chk({tag, "_exp_left"}, exp_q.size(), 0);
        exp_q.delete();
        chk({tag, "_done_cnt"}, done_cnt, int'(exp_done));
        chk({tag, "_mask"}, int'(locked_mask_o), int'(model_mask));
        chk({tag, "_error"}, int'(error_o), int'(m_error));
        if (exp_fail) chk({tag, "_err_ch"}, int'(err_ch_o), exp_err_ch);
        chk({tag, "_busy"}, int'(busy_o), 0);
        chk({tag, "_valid"}, int'(tif.cmd_valid_o), 0);
        done_cnt = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n, c1;
        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; unlock_req_i = 1'b0;
        set_clean();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", int'(tif.cmd_valid_o), 0);
        chk("rst_cmd", int'(tif.cmd_o), int'(CMD_INIT));
        chk("rst_ch", int'(tif.ch_sel_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_error", int'(error_o), 0);
        chk("rst_err_ch", int'(err_ch_o), 0);
        chk("rst_mask", int'(locked_mask_o), 0);
        @(posedge clk); #1 rst = 1'b0;
        done_cnt = 0;

        // Clean pass, DONE 5 cycles after each command, always ready
        build_expect(); pulse_start(); finish_pass("clean");
        build_unlock(); pulse_unlock(); finish_pass("unlock");

        // Ch 2 SEARCH errors twice, then succeeds
        set_clean(); set_pol(2, 1, 2, 1'b0);
        build_expect(); pulse_start(); finish_pass("retry");

        // Ch 1 never answers: every attempt times out
        set_clean(); set_pol(1, 0, 0, 1'b1);
        hs_cyc_q.delete();
        build_expect(); pulse_start(); finish_pass("hang");
        chk("hang_hs_count", hs_cyc_q.size(), 6);
        if (hs_cyc_q.size() == 6) begin
            chk("hang_gap1", hs_cyc_q[4] - hs_cyc_q[3], TMO + 1);
            chk("hang_gap2", hs_cyc_q[5] - hs_cyc_q[4], TMO + 1);
        end

        // Ready held low for 7 cycles on ch 0 INIT; handshake lands in the 8th
        set_clean(); rdy_mode = 2; hs_cyc_q.delete();
        build_expect(); pulse_start();
        @(negedge clk);
        c1 = cyc;
        chk("stall_valid_cycle1", int'(tif.cmd_valid_o), 1);
        repeat (6) @(negedge clk);
        rdy_mode = 0;
        finish_pass("stall");
        chk("stall_hs_cycle", (hs_cyc_q.size() > 0) ? hs_cyc_q[0] - c1 + 1 : -1, 8);

        // Unlock of a full mask, then unlock with nothing locked
        build_unlock(); pulse_unlock(); finish_pass("unlock2");
        build_unlock(); pulse_unlock(); finish_pass("unlock_empty");

        // Abort together with start: start ignored
        base = hs_seen;
        @(posedge clk); #1 begin start_i = 1'b1; abort_i = 1'b1; end
        @(posedge clk); #1 begin start_i = 1'b0; abort_i = 1'b0; end
        @(negedge clk);
        chk("abort_start_busy", int'(busy_o), 0);
        chk("abort_start_valid", int'(tif.cmd_valid_o), 0);
        repeat (4) @(negedge clk);
        chk("abort_start_no_hs", hs_seen - base, 0);

        // Abort while waiting on ch 2 INIT
        set_clean(); base = hs_seen;
        build_expect(); pulse_start();
        n = 0;
        while (hs_seen < base + 7 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("abort_reached_ch2", hs_seen - base, 7);
        repeat (2) @(posedge clk);
        pulse_abort();
        @(negedge clk);
        chk("abort_mid_valid", int'(tif.cmd_valid_o), 0);
        chk("abort_mid_busy", int'(busy_o), 0);
        chk("abort_mid_mask", int'(locked_mask_o), 3);
        chk("abort_mid_exp_left", exp_q.size(), 5);
        exp_q.delete();
        model_mask = 4'b0011; m_in_fail = 1'b0;
        repeat (20) @(posedge clk);
        done_cnt = 0;

        // Reset in the middle of a pass
        set_clean();
        build_expect(); pulse_start();
        repeat (40) @(posedge clk);
        chk("midrst_pre_mask_nonzero", int'(locked_mask_o != 0), 1);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", int'(tif.cmd_valid_o), 0);
        chk("midrst_busy", int'(busy_o), 0);
        chk("midrst_mask", int'(locked_mask_o), 0);
        chk("midrst_cmd", int'(tif.cmd_o), int'(CMD_INIT));
        chk("midrst_ch", int'(tif.ch_sel_o), 0);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        exp_q.delete();
        model_mask = '0; m_error = 1'b0; m_in_fail = 1'b0; done_cnt = 0;

        // Randomized passes and unlocks
        rdy_mode = 1; rand_dly = 1'b1;
        for (int it = 0; it < 16; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                if (m_in_fail) begin
                    pulse_abort();
                    repeat (2) @(posedge clk);
                    m_in_fail = 1'b0;
                end
                build_unlock(); pulse_unlock(); finish_pass("rnd_unlock");
            end else begin
                for (int c = 0; c < NUM_CH; c++)
                    for (int s = 0; s < 3; s++)
                        set_pol(c, s,
                                ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0,
                                ($urandom_range(0, 47) == 0));
                build_expect(); pulse_start(); finish_pass("rnd_pass");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
